stopwatch_core: RTL
===================

# stopwatch_core

Tenths-resolution stopwatch that consumes the ~10 Hz square wave from the 5M clock divider and counts M:SS.t in BCD for the seven-segment display driver. It runs in the fast clk_in domain and uses the divider output only as a rising-edge event, never as a clock. Start/stop, clear and an optional lap-hold come from debounced single-cycle button pulses.

## Interface
- MIN_LIMIT, 9: highest minutes value before wrap (1–9)
- clk_in  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- tick_in  in  1  divided square wave from the divider, same clock domain; rising edge = 0.1 s
- start_stop  in  1  single-cycle pulse; toggles run/pause
- clear  in  1  single-cycle pulse; zero everything
- lap  in  1  single-cycle pulse; toggles display freeze (LAP feature only)
- disp_tenths  out  4  BCD tenths, 0–9
- disp_sec_ones  out  4  BCD seconds units, 0–9
- disp_sec_tens  out  4  BCD seconds tens, 0–5
- disp_min  out  4  BCD minutes, 0–MIN_LIMIT
- running  out  1  high in RUNNING
- lap_active  out  1  display frozen
- overflow  out  1  sticky; set on wrap past MIN_LIMIT:59.9

## Operation
- States: IDLE, RUNNING, PAUSED. Reset → IDLE.
- IDLE --start_stop--> RUNNING; RUNNING --start_stop--> PAUSED; PAUSED --start_stop--> RUNNING; any state --clear--> IDLE.
- Tick detect: tick_q registers tick_in; tick_evt = tick_in & ~tick_q. Falling edges ignored.
- Count: in RUNNING, each tick_evt increments the chain tenths(9→0, carry) → sec_ones(9→0) → sec_tens(5→0) → min(MIN_LIMIT→0). Full wrap M:59.9 → 0:00.0 sets overflow; counting continues.
- Priority within one cycle: clear > start_stop/lap > tick.
  - clear with anything: counters, overflow, lap_active → 0; state IDLE; tick ignored.
  - RUNNING + start_stop + tick_evt: tick counted, state → PAUSED.
  - IDLE/PAUSED + start_stop + tick_evt: tick not counted, state → RUNNING.
- PAUSED holds counters; tick_evt ignored.
- Unused digit bits always 0; all outputs registered.

## Timing
- Reset values: all disp_* = 0, running = 0, lap_active = 0, overflow = 0, tick_q = 0, state IDLE.
- Tick latency: tick_in first sampled high at edge N (tick_q = 0) → new digits visible after edge N, i.e. one clk_in cycle after tick_in rises.
- start_stop at edge N → running valid after edge N.
- Reset assertion mid-count clears immediately (asynchronous); release aligns to clk_in; first tick_evt possible one cycle after release only if tick_in low at release (tick_q resets to 0, so tick_in already high at release counts as an edge; intended).

## Configuration
- STOPWATCH_LAP_EN defined: lap pulse in RUNNING or PAUSED toggles lap_active; while set, disp_* hold the value captured at the lap pulse while the internal count continues; second lap pulse reloads disp_* from the live count the same cycle; clear or reset drops lap_active. lap in IDLE ignored.
- Undefined: lap ignored, lap_active tied 0, disp_* are the live counters.

## Structure
- stopwatch_pkg: state enum (IDLE, RUNNING, PAUSED), constants TENTHS_MAX = 9, SEC_ONES_MAX = 9, SEC_TENS_MAX = 5.
- Sub-module bcd_digit: 4-bit counter with inc, clr, programmable max; outputs value and carry (inc & value == max). Four instances chained.

## Test plan
- Reset low for 3 cycles then start_stop, 25 tick rising edges → disp = 0:02.5, running = 1, overflow = 0.
- Count to 0:59.9, one more tick → 1:00.0; with MIN_LIMIT = 1, from 1:59.9 one tick → 0:00.0, overflow = 1 and stays 1 until clear.
- RUNNING with start_stop and tick_evt in same cycle at 0:00.3 → 0:00.4, PAUSED; 5 further ticks → stays 0:00.4.
- clear coincident with tick_evt at 0:07.2 → 0:00.0, IDLE, overflow = 0; following tick → unchanged.
- LAP_EN: lap at 0:01.0, 20 ticks → disp stays 0:01.0, lap_active = 1; second lap → disp 0:03.0 next cycle.
- reset_n pulsed low mid-cycle at 0:04.4 (between clk_in edges) → all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the tenths-resolution stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_e;

  localparam int TENTHS_MAX   = 9;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: wraps MAX->0 on inc, carry is combinational (inc at MAX).
// Latency: value updates on the clock after inc; clr wins over inc.
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] value_o,
  output logic       carry_o
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] value_q, value_d;
  logic       at_max;

  assign at_max  = (value_q == MAX_V);
  assign carry_o = inc_i & at_max;
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (clr_i)
      value_d = 4'd0;
    else if (inc_i)
      value_d = at_max ? 4'd0 : value_q + 4'd1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) value_q <= 4'd0;
    else          value_q <= value_d;
  end

endmodule

// File: rtl/stopwatch_core.sv
// M:SS.t BCD stopwatch counting rising edges of a ~10 Hz tick in the clk_in domain.
// Optional display freeze (lap hold) is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT = 9
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] disp_tenths,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  sw_state_e state_q, state_d;
  logic      tick_q;
  logic      running_q;
  logic      overflow_q, overflow_d;
  logic      tick_evt, count_en;
  logic      c_tenths, c_ones, c_tens, c_min;
  logic [3:0] tenths, sec_ones, sec_tens, minutes;

  assign tick_evt = tick_in & ~tick_q;
  // A start_stop in RUNNING still counts the coincident tick: gating uses the current state.
  assign count_en = (state_q == RUNNING) & tick_evt & ~clear;

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = IDLE;
    else if (start_stop)
      state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
  end

  assign overflow_d = clear ? 1'b0 : (overflow_q | c_min);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_in;
      running_q  <= (state_d == RUNNING);
      overflow_q <= overflow_d;
    end
  end

  bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
    .clk_in(clk_in), .reset_n(reset_n), .inc_i(count_en), .clr_i(clear),
    .value_o(tenths), .carry_o(c_tenths)
  );
  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk_in(clk_in), .reset_n(reset_n), .inc_i(c_tenths), .clr_i(clear),
    .value_o(sec_ones), .carry_o(c_ones)
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_in(clk_in), .reset_n(reset_n), .inc_i(c_ones), .clr_i(clear),
    .value_o(sec_tens), .carry_o(c_tens)
  );
  bcd_digit #(.MAX(MIN_LIMIT)) u_min (
    .clk_in(clk_in), .reset_n(reset_n), .inc_i(c_tens), .clr_i(clear),
    .value_o(minutes), .carry_o(c_min)
  );

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_q;
  logic [15:0] hold_q;
  logic        lap_go;

  assign lap_go = lap & ~clear & (state_q != IDLE);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      lap_q  <= 1'b0;
      hold_q <= 16'd0;
    end else begin
      if (clear)
        lap_q <= 1'b0;
      else if (lap_go)
        lap_q <= ~lap_q;
      if (lap_go && !lap_q)
        hold_q <= {minutes, sec_tens, sec_ones, tenths};
    end
  end

  // Frozen view comes from hold_q; releasing the lap shows the live count immediately.
  assign lap_active = lap_q;
  assign {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths} =
      lap_q ? hold_q : {minutes, sec_tens, sec_ones, tenths};
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths} =
      {minutes, sec_tens, sec_ones, tenths};
`endif

endmodule
